// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction queue between the fetch stage's imem interface
// and decode. Each returned word is stored with its fetch PC, and the oldest
// entry is presented to decode. Fetch is back-pressured when the queue is
// nearly full. All entries are discarded on a speculative redirect.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous active-low reset
//   in_pc      fetch PC of the word on in_rdata
//   in_rdata   instruction word returned by imem
//   in_ready   in_pc/in_rdata valid this cycle (push request)
//   in_clear   flush all entries (redirect); wins over push and pop
//   in_stall   downstream stall; blocks pop only
//   out_pc     PC of head entry (0 when empty)
//   out_instr  instruction of head entry (NOP when empty)
//   out_done   head entry valid
//   out_stall  fetch must not issue a new request
//   overflow   sticky: a push was dropped because the queue was full
module fetch_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rdata,
  input  logic        in_ready,
  input  logic        in_clear,
  input  logic        in_stall,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_done,
  output logic        out_stall,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = in_ready & ~in_clear & ~full;
  assign pop   = ~in_stall & ~in_clear & ~empty;
  // A push arriving at full is lost even if a pop frees a slot the same cycle.
  assign drop  = in_ready & ~in_clear & full;

  // Pointer, occupancy and overflow state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      if (in_clear) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          wptr <= wptr + AW'(1);
        end
        if (pop) begin
          rptr <= rptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (reset && push) begin
      pc_mem[wptr]    <= in_pc;
      instr_mem[wptr] <= in_rdata;
    end
  end

  // Head presentation depends on registered state only.
  assign out_done  = ~empty;
  assign out_pc    = out_done ? pc_mem[rptr] : 32'h0;
  assign out_instr = out_done ? instr_mem[rptr] : NOP;
  // One imem response may already be in flight, so keep one slot in reserve.
  assign out_stall = (count >= CW'(DEPTH - 1));

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic [31:0] in_pc;
  logic [31:0] in_rdata;
  logic        in_ready;
  logic        in_clear;
  logic        in_stall;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_done;
  logic        out_stall;
  logic        overflow;

  int checks;
  int errors;

  fetch_buffer #(.DEPTH(4), .NOP(NOP)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_pc    (in_pc),
    .in_rdata (in_rdata),
    .in_ready (in_ready),
    .in_clear (in_clear),
    .in_stall (in_stall),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .out_done (out_done),
    .out_stall(out_stall),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [31:0] pc, input logic stl, input logic clr);
    in_ready = rdy;
    in_pc    = pc;
    in_rdata = word_of(pc);
    in_stall = stl;
    in_clear = clr;
  endtask

  task automatic apply_reset();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", out_done); end
    checks++; if (out_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", out_instr, NOP); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", out_pc); end
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", out_stall); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_streaming();
    logic [31:0] pc;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      pc = 32'h8000_0000 + 32'(4 * k);
      drive(1'b1, pc, 1'b0, 1'b0);
      tick();
      checks++; if (out_pc !== pc) begin errors++; $display("FAIL stream_pc%0d got %h want %h", k, out_pc, pc); end
      checks++; if (out_instr !== word_of(pc)) begin errors++; $display("FAIL stream_instr%0d got %h want %h", k, out_instr, word_of(pc)); end
      checks++; if (out_done !== 1'b1 || out_stall !== 1'b0) begin errors++; $display("FAIL stream_flags%0d got done=%b stall=%b want 1 0", k, out_done, out_stall); end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++; if (out_done !== 1'b0 || out_instr !== NOP) begin errors++; $display("FAIL stream_drain got done=%b instr=%h want 0 %h", out_done, out_instr, NOP); end
  endtask

  task automatic test_fill();
    logic [31:0] pc;
    logic        exp_stall;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      pc = 32'h10 + 32'(4 * k);
      drive(1'b1, pc, 1'b1, 1'b0);
      tick();
      exp_stall = (k >= 2);
      checks++; if (out_stall !== exp_stall) begin errors++; $display("FAIL fill_stall%0d got %b want %b", k, out_stall, exp_stall); end
      checks++; if (overflow !== (k == 4)) begin errors++; $display("FAIL fill_overflow%0d got %b want %b", k, overflow, (k == 4)); end
      checks++; if (out_pc !== 32'h10) begin errors++; $display("FAIL fill_head%0d got %h want 00000010", k, out_pc); end
    end
    // Drain: the four accepted words appear in order, the dropped 0x20 never does.
    for (int k = 1; k < 5; k++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      pc = (k < 4) ? 32'h10 + 32'(4 * k) : 32'h0;
      checks++; if (out_pc !== pc || out_done !== (k < 4)) begin errors++; $display("FAIL fill_drain%0d got pc=%h done=%b want %h %b", k, out_pc, out_done, pc, (k < 4)); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_sticky got %b want 1", overflow); end
  endtask

  task automatic test_wrap();
    logic [31:0] model[$];
    logic [31:0] seen[$];
    int          sent;
    logic        stl;
    logic        rdy;
    logic        do_pop;
    apply_reset();
    sent = 0;
    for (int c = 0; c < 60 && seen.size() < 10; c++) begin
      stl = ((c % 3) == 1) || ((c % 7) == 0);
      rdy = (sent < 10) && (model.size() < 4) && ((c % 5) != 4);
      drive(rdy, 32'h100 + 32'(4 * sent), stl, 1'b0);
      do_pop = !stl && (model.size() != 0);
      if (do_pop) seen.push_back(out_pc);
      tick();
      if (do_pop) void'(model.pop_front());
      if (rdy) begin
        model.push_back(32'h100 + 32'(4 * sent));
        sent++;
      end
      checks++; if (out_done !== (model.size() != 0)) begin errors++; $display("FAIL wrap_done c%0d got %b want %b", c, out_done, (model.size() != 0)); end
      if (model.size() != 0) begin
        checks++; if (out_pc !== model[0]) begin errors++; $display("FAIL wrap_head c%0d got %h want %h", c, out_pc, model[0]); end
      end
    end
    checks++; if (seen.size() != 10) begin errors++; $display("FAIL wrap_count got %0d want 10", seen.size()); end
    for (int k = 0; k < seen.size() && k < 10; k++) begin
      checks++; if (seen[k] !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL wrap_seq%0d got %h want %h", k, seen[k], 32'h100 + 32'(4 * k)); end
    end
  endtask

  task automatic test_clear();
    apply_reset();
    drive(1'b1, 32'h300, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h304, 1'b1, 1'b0); tick();
    checks++; if (out_pc !== 32'h300) begin errors++; $display("FAIL clear_pre got %h want 00000300", out_pc); end
    drive(1'b1, 32'h200, 1'b0, 1'b1); tick();
    checks++; if (out_done !== 1'b0 || out_stall !== 1'b0) begin errors++; $display("FAIL clear_flags got done=%b stall=%b want 0 0", out_done, out_stall); end
    checks++; if (out_pc !== 32'h0 || out_instr !== NOP) begin errors++; $display("FAIL clear_out got pc=%h instr=%h want 0 %h", out_pc, out_instr, NOP); end
    drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
    checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL clear_nolate got done=%b pc=%h want 0", out_done, out_pc); end
    drive(1'b1, 32'h400, 1'b1, 1'b0); tick();
    checks++; if (out_pc !== 32'h400 || out_done !== 1'b1) begin errors++; $display("FAIL clear_restart got pc=%h done=%b want 00000400 1", out_pc, out_done); end
  endtask

  task automatic test_full_pushpop();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h500 + 32'(4 * k), 1'b1, 1'b0);
      tick();
    end
    checks++; if (overflow !== 1'b0 || out_stall !== 1'b1) begin errors++; $display("FAIL full_pre got ovf=%b stall=%b want 0 1", overflow, out_stall); end
    drive(1'b1, 32'h600, 1'b0, 1'b0); tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf got %b want 1", overflow); end
    checks++; if (out_pc !== 32'h504 || out_stall !== 1'b1) begin errors++; $display("FAIL full_pop got pc=%h stall=%b want 00000504 1", out_pc, out_stall); end
    for (int k = 2; k < 5; k++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
      checks++; if (out_pc !== ((k < 4) ? 32'h500 + 32'(4 * k) : 32'h0)) begin errors++; $display("FAIL full_drain%0d got %h", k, out_pc); end
    end
    checks++; if (out_done !== 1'b0 || out_stall !== 1'b0) begin errors++; $display("FAIL full_empty got done=%b stall=%b want 0 0", out_done, out_stall); end
    drive(1'b0, 32'h0, 1'b0, 1'b1); tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_clear_keeps_ovf got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1'b1, 32'h700, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h704, 1'b1, 1'b0); tick();
    checks++; if (out_done !== 1'b1) begin errors++; $display("FAIL mid_pre got %b want 1", out_done); end
    drive(1'b1, 32'h708, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (out_done !== 1'b0 || out_pc !== 32'h0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_reset got done=%b pc=%h ovf=%b want 0 0 0", out_done, out_pc, overflow); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    test_reset();
    test_streaming();
    test_fill();
    test_wrap();
    test_clear();
    test_full_pushpop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
